// File: rtl/spike_dec_pkg.sv
// spike_dec_pkg: shared state type, default widths and saturating increment for the spike rate decoder.
package spike_dec_pkg;
   typedef enum logic {IDLE, COUNT} spk_dec_state_t;
   localparam int SPK_WIN_W = 8;
   localparam int SPK_CNT_W = 8;
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v, input logic inc);
      return (inc && v < max_v) ? v + 32'd1 : v;
   endfunction
endpackage

// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if: rate word valid/ready output bus; SPIKE_ISI_EN adds the inter-spike-interval outputs.
interface spike_rate_decoder_if #(
   parameter int CNT_W = spike_dec_pkg::SPK_CNT_W
`ifdef SPIKE_ISI_EN
   , parameter int WIN_W = spike_dec_pkg::SPK_WIN_W
`endif
);
   logic [CNT_W-1:0] rate;
   logic rate_valid;
   logic rate_ready;
   logic overrun;
`ifdef SPIKE_ISI_EN
   logic [WIN_W-1:0] isi;
   logic isi_valid;
   modport master (output rate, rate_valid, overrun, isi, isi_valid, input rate_ready);
   modport slave (input rate, rate_valid, overrun, isi, isi_valid, output rate_ready);
`else
   modport master (output rate, rate_valid, overrun, input rate_ready);
   modport slave (input rate, rate_valid, overrun, output rate_ready);
`endif
endinterface

// File: rtl/spike_edge_detect.sv
// spike_edge_detect: one-cycle delayed copy of the spike stream and its rising-edge strobe.
module spike_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic spike_in,
   output logic rise
);
   logic spk_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) spk_d <= 1'b0;
      else spk_d <= spike_in;
   assign rise = spike_in & ~spk_d;
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spike rising edges over back-to-back programmable windows and emits per-window rate words.
// Define SPIKE_ISI_EN to add the inter-spike-interval outputs (isi, isi_valid).
module spike_rate_decoder
   import spike_dec_pkg::*;
#(
   parameter int WIN_W = SPK_WIN_W,
   parameter int CNT_W = SPK_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             spike_in,
   input  logic [WIN_W-1:0] window_len,
   spike_rate_decoder_if.master rif
);
   spk_dec_state_t state;
   logic [WIN_W-1:0] win_cnt, win_len_q;
   logic [CNT_W-1:0] spk_cnt, spk_next;
   logic rise, counted, term, xfer;
   spike_edge_detect u_edge (.clk, .rst_n, .spike_in, .rise);
   assign counted = state == COUNT && en && rise;
   assign term = state == COUNT && en && win_cnt == win_len_q;
   assign spk_next = CNT_W'(sat_inc(32'(spk_cnt), 32'({CNT_W{1'b1}}), counted));
   assign xfer = rif.rate_valid && rif.rate_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         win_cnt <= '0;
         win_len_q <= '0;
         spk_cnt <= '0;
         rif.rate <= '0;
         rif.rate_valid <= 1'b0;
         rif.overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rif.overrun <= 1'b0;
               win_cnt <= '0;
               spk_cnt <= '0;
               if (en) begin
                  state <= COUNT;
                  win_len_q <= window_len;
               end
            end
            COUNT: begin
               if (!en) begin
                  state <= IDLE;
                  win_cnt <= '0;
                  spk_cnt <= '0;
               end else if (term) begin
                  win_cnt <= '0;
                  spk_cnt <= '0;
                  win_len_q <= window_len;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
                  spk_cnt <= spk_next;
               end
            end
            default: state <= IDLE;
         endcase
         // A load wins over a transfer; only an unconsumed word being replaced is an overrun
         if (term) begin
            rif.rate <= spk_next;
            rif.rate_valid <= 1'b1;
            if (rif.rate_valid && !rif.rate_ready) rif.overrun <= 1'b1;
         end else if (xfer) begin
            rif.rate_valid <= 1'b0;
         end
      end
   end
`ifdef SPIKE_ISI_EN
   logic [WIN_W-1:0] isi_cnt;
   logic isi_seen;
   // isi_cnt holds the distance from the last counted edge to the current cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isi_cnt <= '0;
         isi_seen <= 1'b0;
         rif.isi <= '0;
         rif.isi_valid <= 1'b0;
      end else if (state == IDLE) begin
         isi_cnt <= '0;
         isi_seen <= 1'b0;
         rif.isi_valid <= 1'b0;
      end else begin
         rif.isi_valid <= counted && isi_seen;
         if (counted) begin
            isi_seen <= 1'b1;
            isi_cnt <= WIN_W'(1);
            if (isi_seen) rif.isi <= isi_cnt;
         end else if (isi_seen) begin
            isi_cnt <= WIN_W'(sat_inc(32'(isi_cnt), 32'({WIN_W{1'b1}}), 1'b1));
         end
      end
   end
`endif
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: scoreboard bench; expected rate words come from edge counts over planned window slices.
module tb_spike_rate_decoder;
   logic clk = 1'b0;
   logic rst_n, en, spike_in, ready;
   logic [7:0] window_len;
   int n_chk = 0, n_fail = 0, vcount = 0;
   int q8[$], q4[$];
   int e8, e4;
   spike_rate_decoder_if #(.CNT_W(8)) rif ();
   spike_rate_decoder_if #(.CNT_W(4)) rif4 ();
   assign rif.rate_ready = ready;
   assign rif4.rate_ready = ready;
   spike_rate_decoder #(.WIN_W(8), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in), .window_len(window_len), .rif(rif));
   spike_rate_decoder #(.WIN_W(8), .CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in), .window_len(window_len), .rif(rif4));
   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic bit spk(input bit s[$], input int t);
      return (t >= 0 && t < s.size()) ? s[t] : 1'b0;
   endfunction

   function automatic void push_word(input int c);
      q8.push_back(c > 255 ? 255 : c);
      q4.push_back(c > 15 ? 15 : c);
   endfunction

   // Monitor: every accepted word is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (rst_n) begin
         if (rif.rate_valid) vcount++;
         if (rif.rate_valid && rif.rate_ready) begin
            if (q8.size() == 0) check("unexpected_word8", 1, 0);
            else begin
               e8 = q8.pop_front();
               check("rate8", int'(rif.rate), e8);
            end
            check("overrun8", int'(rif.overrun), 0);
         end
         if (rif4.rate_valid && rif4.rate_ready) begin
            if (q4.size() == 0) check("unexpected_word4", 1, 0);
            else begin
               e4 = q4.pop_front();
               check("rate4", int'(rif4.rate), e4);
            end
            check("overrun4", int'(rif4.overrun), 0);
         end
      end
   end

   // sp[0] is the idle cycle where en is first sampled; window cycles follow from index 1
   task automatic run_seg(input int lens[$], input bit sp[$], input int partial, input bit keep_last, input bit drop_en);
      int pos = 1, c, total;
      int term[$];
      foreach (lens[i]) begin
         c = 0;
         for (int k = pos; k <= pos + lens[i]; k++) c += int'(spk(sp, k) && !spk(sp, k - 1));
         if (!keep_last || i == lens.size() - 1) push_word(c);
         term.push_back(pos + lens[i]);
         pos += lens[i] + 1;
      end
      total = pos + partial;
      for (int t = 0; t < total; t++) begin
         en = 1'b1;
         spike_in = spk(sp, t);
         window_len = (t == 0) ? 8'(lens[0]) : 8'($urandom_range(0, 255));
         foreach (term[i]) if (t == term[i]) window_len = (i + 1 < lens.size()) ? 8'(lens[i + 1]) : 8'd255;
         @(posedge clk);
         #1;
      end
      if (drop_en) repeat (2) begin
         en = 1'b0;
         spike_in = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rand_sp(input int n, input int p, output bit sp[$]);
      sp.delete();
      for (int i = 0; i < n; i++) sp.push_back($urandom_range(0, p) == 0);
   endtask

   initial begin
      int lens[$];
      bit sp[$];
      int v0, tot, r, part;
      rst_n = 1'b0; en = 1'b0; spike_in = 1'b0; window_len = '0; ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rate", int'(rif.rate), 0);
      check("reset_valid", int'(rif.rate_valid), 0);
      check("reset_overrun", int'(rif.overrun), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Rate recovery: pulse every other cycle, window of 10
      lens = '{9, 9, 9, 9, 9};
      sp.delete();
      for (int t = 0; t <= 50; t++) sp.push_back(t % 2 == 1);
      v0 = vcount;
      run_seg(lens, sp, 0, 0, 1);
      check("valid_cycles", vcount - v0, 5);
      // Level held 6 cycles counts once; level already high at enable counts zero
      lens = '{15};
      sp.delete();
      for (int t = 0; t <= 16; t++) sp.push_back(t >= 4 && t <= 9);
      run_seg(lens, sp, 0, 0, 1);
      sp.delete();
      for (int t = 0; t <= 16; t++) sp.push_back(1'b1);
      run_seg(lens, sp, 0, 0, 1);
      // Saturation of the narrow counter
      lens = '{255};
      sp.delete();
      for (int t = 0; t <= 256; t++) sp.push_back(t % 2 == 1);
      run_seg(lens, sp, 0, 0, 1);
      // Single-cycle windows: load and transfer on the same cycle
      lens = '{0, 0, 0, 0};
      rand_sp(5, 1, sp);
      run_seg(lens, sp, 0, 0, 1);
      // Random windows, spike densities and discarded partial windows
      for (int s = 0; s < 10; s++) begin
         lens.delete();
         tot = 1;
         for (int i = 0; i < $urandom_range(1, 4); i++) begin
            r = $urandom_range(0, 3);
            lens.push_back(r == 0 ? 0 : r == 1 ? 1 : $urandom_range(2, 40));
            tot += lens[$] + 1;
         end
         part = $urandom_range(0, 10);
         rand_sp(tot + part, $urandom_range(1, 3), sp);
         run_seg(lens, sp, part, 0, 1);
      end
      check("drain_random", q8.size() + q4.size(), 0);
      // Backpressure over two windows: second word overwrites the first
      ready = 1'b0;
      lens = '{3, 3};
      rand_sp(10, 1, sp);
      run_seg(lens, sp, 1, 1, 0);
      check("bp_rate8", int'(rif.rate), q8[$]);
      check("bp_rate4", int'(rif4.rate), q4[$]);
      check("bp_valid", int'(rif.rate_valid), 1);
      check("bp_overrun", int'(rif.overrun), 1);
      // Asynchronous reset mid-window
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rate", int'(rif.rate), 0);
      check("arst_valid", int'(rif.rate_valid), 0);
      check("arst_overrun", int'(rif.overrun), 0);
      check("arst_overrun4", int'(rif4.overrun), 0);
      q8.delete();
      q4.delete();
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Enable drops at cycle 5 of the next window: pending word kept, partial discarded
      lens = '{3};
      rand_sp(11, 1, sp);
      run_seg(lens, sp, 5, 0, 1);
      check("hold_valid", int'(rif.rate_valid), 1);
      check("hold_rate8", int'(rif.rate), q8[0]);
      check("hold_rate4", int'(rif4.rate), q4[0]);
      check("hold_overrun", int'(rif.overrun), 0);
      ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("drain_final", q8.size() + q4.size(), 0);
      check("final_valid", int'(rif.rate_valid), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receive-side decoder for QIF neuron spike trains. Counts rising edges of a one-bit spike stream over a programmable, back-to-back window and presents each window's spike count as an 8-bit rate word on a valid/ready interface. This recovers a magnitude from a neuron's `spike_out`, so downstream logic and test harnesses can read firing rate instead of raw pulses.

## Interface
- `WIN_W`, default 8: width of window-length field and window counter.
- `CNT_W`, default 8: width of the spike counter and of `rate`.

Ports:
- `clk` input 1: single clock; all logic rises on posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: decoder enable; low holds the decoder idle.
- `spike_in` input 1: spike stream, sampled on `clk`.
- `window_len` input `WIN_W`: window length minus one, in cycles. Sampled at each window start.
- `rate` output `CNT_W`: spike count of the last completed window.
- `rate_valid` output 1: `rate` holds an unconsumed word.
- `rate_ready` input 1: consumer accepts `rate` when high with `rate_valid`.
- `overrun` output 1: sticky flag. Set when an unconsumed word was overwritten.

## Operation
- Edge detect: `spk_d` is a register of `spike_in` and updates every cycle in every state. An edge is `spike_in & ~spk_d`. A level held high counts once. A spike already high when `en` rises is not counted.
- FSM states: IDLE and COUNT.
  - IDLE, `en`=1: go to COUNT, `win_cnt`=0, `spk_cnt`=0, latch `win_len_q`=`window_len`.
  - COUNT, `en`=0: go to IDLE. The partial window is discarded and `win_cnt`/`spk_cnt` are cleared.
  - `rate`/`rate_valid` are untouched on this transition. A pending word stays available.
- Counting in COUNT: an edge increments `spk_cnt`. The add saturates at 2^CNT_W−1 and does not wrap.
- Terminal cycle, when `win_cnt`==`win_len_q`:
  - `rate` ← `spk_cnt` + edge this cycle, saturated.
  - `rate_valid` ← 1.
  - `win_cnt` ← 0 and `spk_cnt` ← 0.
  - `win_len_q` ← `window_len`.
  - The next window starts immediately, with no gap cycle.
- Handshake: the transfer happens on a cycle with `rate_valid`&&`rate_ready`.
  - With no new load that cycle, `rate_valid` ← 0.
  - `rate` and `rate_valid` change only on a load or a transfer.
- Simultaneous terminal cycle and transfer: the new word loads and `rate_valid` stays 1. `overrun` is not set.
- Terminal cycle with `rate_valid`=1 and no transfer: the new word overwrites `rate` and `overrun` ← 1.
- `overrun` clears only on reset or in IDLE.
- `window_len`=0: every cycle is a terminal cycle. `rate` is 0 or 1 each cycle.
- Reset values:
  - `rate`=0, `rate_valid`=0, `overrun`=0.
  - State IDLE.
  - `spk_d`=0 and all counters 0.
- Reset mid-window: everything returns to reset values asynchronously. No word is emitted for the partial window.

## Timing
- Window period is exactly `window_len`+1 cycles.
- Window cycle 0 is the first cycle in COUNT, one cycle after `en` is sampled high in IDLE.
- An edge on `spike_in` at window cycle k is counted in that window for 0 ≤ k ≤ `win_len_q`.
- `rate_valid` rises one cycle after the terminal cycle, with `rate` updated on the same edge.
- `rate_valid` falls one cycle after the accepting cycle.
- A new `window_len` takes effect at the start of the next window. Changes mid-window have no effect.

## Configuration
- `SPIKE_ISI_EN` defined: adds two outputs.
  - `isi` output `WIN_W`: the cycle count between the last two counted edges, saturating at 2^WIN_W−1.
  - `isi_valid` output 1: a one-cycle pulse on each edge after the first edge since leaving IDLE.
  - Both reset to 0. The ISI counter clears in IDLE.
  - Two edges k cycles apart give `isi`=k.
- `SPIKE_ISI_EN` undefined: no ISI ports and no ISI logic. All other behaviour is identical.

## Structure
- Package `spike_dec_pkg` holds:
  - the state enum `spk_dec_state_t` (IDLE, COUNT);
  - default widths `SPK_WIN_W`=8 and `SPK_CNT_W`=8;
  - a saturating-increment function used by the spike counter and the ISI counter.
- Sub-module `spike_edge_detect`: the `spk_d` register plus rising-edge output, with async active-low reset. The top level instantiates it once.

## Test plan
- Rate recovery: `window_len`=9, spike pulse every 2 cycles, `rate_ready`=1 → `rate`=5 at every window. `rate_valid` is high for 1 cycle every 10 cycles.
- Level vs edge: `spike_in` held high 6 cycles inside a window with `window_len`=15 → `rate`=1. High at `en` rise and through window 0 → `rate`=0.
- Saturation: `window_len`=255 with `CNT_W`=4, spike every other cycle → `rate`=15. `overrun`=0 when `rate_ready`=1.
- Backpressure: `rate_ready`=0 across two windows with `window_len`=3 → second word overwrites the first and `overrun`=1. A transfer on a terminal cycle → `rate_valid` stays 1 and `overrun` is not newly set.
- Enable/reset mid-window: `en`=0 at window cycle 5 → no word emitted and the pending word is retained. `rst_n`=0 mid-window → `rate`=0, `rate_valid`=0, `overrun`=0 immediately.
- `SPIKE_ISI_EN`: edges at cycles 3, 10 and 14 after entering COUNT → `isi`=7 then 4, each with a one-cycle `isi_valid`. No pulse on the first edge.
